// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants for the pipeline control slice: mult/div latencies,
// exception entry point and the ExcCode values used by the pipeline registers.
package pipeline_sequencer_pkg;

  localparam int          MULT_CYCLES = 5;
  localparam int          DIV_CYCLES  = 10;
  localparam int          CNT_W       = 4;
  localparam logic [31:0] HANDLER_PC  = 32'h0000_4180;

  // CP0 Cause.ExcCode encodings carried down the pipeline with each instr
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_STALL    = 2'd1,
    CTRL_REDIRECT = 2'd2
  } ctrl_e;

  function automatic logic [31:0] redirect_target(input logic exc_req,
                                                  input logic [31:0] epc_val);
    return exc_req ? HANDLER_PC : epc_val;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_md_busy_counter.sv
// Mult/div busy countdown: loads the op latency on a qualified start and
// counts down to zero; a start while busy or under a redirect is ignored.
module md_busy_counter
  import pipeline_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES_P = MULT_CYCLES,
  parameter int DIV_CYCLES_P  = DIV_CYCLES,
  parameter int CNT_W_P       = CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  input  logic kill_i,
  output logic busy_o,
  output logic fire_o
);

  localparam logic [CNT_W_P-1:0] MULT_LOAD = CNT_W_P'(MULT_CYCLES_P);
  localparam logic [CNT_W_P-1:0] DIV_LOAD  = CNT_W_P'(DIV_CYCLES_P);

  logic [CNT_W_P-1:0] busy_cnt_q, busy_cnt_d;

  assign busy_o = (busy_cnt_q != '0);
  assign fire_o = start_i & ~busy_o & ~kill_i;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (fire_o) begin
      busy_cnt_d = is_div_i ? DIV_LOAD : MULT_LOAD;
    end else if (busy_o) begin
      busy_cnt_d = busy_cnt_q - CNT_W_P'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: merges RAW stalls, HI/LO
// use stalls and M-stage exception/eret redirects into one control set.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES_P = MULT_CYCLES,
  parameter int DIV_CYCLES_P  = DIV_CYCLES,
  parameter int CNT_W_P       = CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_stall,
  input  logic        d_md_use,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        m_exc_req,
  input  logic        m_eret,
  input  logic [31:0] epc,
  output logic        pc_hold,
  output logic        fd_hold,
  output logic        de_bubble,
  output logic        flush_dem,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        md_busy,
  output logic        md_fire
);

  logic  redirect_req;
  logic  cnt_busy;
  logic  cnt_fire;
  logic  md_stall;
  logic  stall;
  ctrl_e ctrl;

  assign redirect_req = m_exc_req | m_eret;

  md_busy_counter #(
    .MULT_CYCLES_P (MULT_CYCLES_P),
    .DIV_CYCLES_P  (DIV_CYCLES_P),
    .CNT_W_P       (CNT_W_P)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (e_md_start),
    .is_div_i (e_md_is_div),
    .kill_i   (redirect_req),
    .busy_o   (cnt_busy),
    .fire_o   (cnt_fire)
  );

  // e_md_start term catches an md instr in D directly behind one in E
  assign md_stall = d_md_use & (cnt_busy | e_md_start);
  assign stall    = hazard_stall | md_stall;

  always_comb begin
    ctrl = CTRL_RUN;
    if (redirect_req) begin
      ctrl = CTRL_REDIRECT;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    fd_hold     = 1'b0;
    de_bubble   = 1'b0;
    flush_dem   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = HANDLER_PC;
    md_busy     = 1'b0;
    md_fire     = 1'b0;
    if (!reset) begin
      md_busy = cnt_busy;
      md_fire = cnt_fire;
      unique case (ctrl)
        CTRL_REDIRECT: begin
          redirect    = 1'b1;
          flush_dem   = 1'b1;
          redirect_pc = redirect_target(m_exc_req, epc);
        end
        CTRL_STALL: begin
          pc_hold   = 1'b1;
          fd_hold   = 1'b1;
          de_bubble = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: each applied input vector pushes
// its expected outputs, popped and compared at the following falling edge.
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hazard_stall, d_md_use, e_md_start, e_md_is_div;
  logic        m_exc_req, m_eret;
  logic [31:0] epc;
  logic        pc_hold, fd_hold, de_bubble, flush_dem, redirect, md_busy, md_fire;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  pipeline_sequencer u_dut (
    .clk          (clk),
    .reset        (reset),
    .hazard_stall (hazard_stall),
    .d_md_use     (d_md_use),
    .e_md_start   (e_md_start),
    .e_md_is_div  (e_md_is_div),
    .m_exc_req    (m_exc_req),
    .m_eret       (m_eret),
    .epc          (epc),
    .pc_hold      (pc_hold),
    .fd_hold      (fd_hold),
    .de_bubble    (de_bubble),
    .flush_dem    (flush_dem),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .md_busy      (md_busy),
    .md_fire      (md_fire)
  );

  wire logic [38:0] obs = {pc_hold, fd_hold, de_bubble, flush_dem, redirect,
                           md_busy, md_fire, redirect_pc};
  wire logic [3:0]  dut_cnt = u_dut.u_md_busy_counter.busy_cnt_q;

  typedef struct packed {
    logic        rst, hs, du, st, dv, ex, er;
    logic [31:0] ep;
  } stim_t;

  typedef struct {
    logic [38:0] v;
    logic [3:0]  cnt;
    logic        chk_cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  model_cnt = 4'bx;
  logic [3:0]  model_cnt_next;
  logic        cnt_known = 1'b0;

  function automatic stim_t mk(input logic rst, hs, du, st, dv, ex, er,
                               input logic [31:0] ep);
    stim_t s;
    s = '{rst: rst, hs: hs, du: du, st: st, dv: dv, ex: ex, er: er, ep: ep};
    return s;
  endfunction

  // Drive one cycle of inputs and record what the outputs must be.
  task automatic apply(input stim_t s);
    exp_t        e;
    logic        busy, fire;
    logic [31:0] tgt;
    reset = s.rst; hazard_stall = s.hs; d_md_use = s.du; e_md_start = s.st;
    e_md_is_div = s.dv; m_exc_req = s.ex; m_eret = s.er; epc = s.ep;
    busy = cnt_known && (model_cnt != 4'd0);
    fire = s.st & ~busy & ~s.ex & ~s.er;
    tgt  = s.ex ? 32'h0000_4180 : s.ep;
    if (s.rst)
      e.v = {7'b0, 32'h0000_4180};
    else if (s.ex | s.er)
      e.v = {5'b00011, busy, fire, tgt};
    else if (s.hs | (s.du & (busy | s.st)))
      e.v = {5'b11100, busy, fire, 32'h0000_4180};
    else
      e.v = {5'b00000, busy, fire, 32'h0000_4180};
    e.cnt     = model_cnt;
    e.chk_cnt = cnt_known;
    sb.push_back(e);
    if (s.rst)      model_cnt_next = 4'd0;
    else if (fire)  model_cnt_next = s.dv ? 4'd10 : 4'd5;
    else if (busy)  model_cnt_next = model_cnt - 4'd1;
    else            model_cnt_next = model_cnt;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_cnt = model_cnt_next;
    cnt_known = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      apply(mk(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), $urandom));
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL reset_outs[%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      if (e.chk_cnt) begin
        n_checks++;
        if (dut_cnt !== e.cnt) $display("FAIL reset_cnt got=%0d want=%0d", dut_cnt, e.cnt);
        else n_pass++;
      end
      advance();
    end
    n_checks++;
    if (redirect_pc !== 32'h0000_4180 || md_busy !== 1'b0)
      $display("FAIL reset_pc got=%h/%b want=00004180/0", redirect_pc, md_busy);
    else n_pass++;
  endtask

  task automatic test_mult();
    exp_t e;
    int   stalls = 0;
    for (int i = 0; i < 7; i++) begin
      apply(mk(1'b0, 1'b0, 1'b1, i == 0, 1'b0, 1'b0, 1'b0, 32'h0));
      @(negedge clk);
      e = sb.pop_front();
      if (pc_hold === 1'b1) stalls++;
      n_checks++;
      if (obs !== e.v) $display("FAIL mult_outs[t+%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      n_checks++;
      if (dut_cnt !== e.cnt) $display("FAIL mult_cnt[t+%0d] got=%0d want=%0d", i, dut_cnt, e.cnt);
      else n_pass++;
      advance();
    end
    n_checks++;
    if (stalls != 6) $display("FAIL mult_stall_len got=%0d want=6", stalls);
    else n_pass++;
  endtask

  task automatic test_div_mflo();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      apply(mk(1'b0, 1'b0, 1'b1, i == 0, 1'b1, 1'b0, 1'b0, 32'h0));
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL div_outs[t+%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      if (i >= 1) begin
        n_checks++;
        if (dut_cnt !== 4'(11 - i)) $display("FAIL div_cnt[t+%0d] got=%0d want=%0d", i, dut_cnt, 11 - i);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_exception();
    exp_t e;
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678));
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e.v) $display("FAIL exc_outs got=%h want=%h", obs, e.v);
    else n_pass++;
    n_checks++;
    if ({redirect, flush_dem, pc_hold, fd_hold} !== 4'b1100 || redirect_pc !== 32'h0000_4180)
      $display("FAIL exc_beats_stall got=%b%b%b%b pc=%h want=1100 pc=00004180",
               redirect, flush_dem, pc_hold, fd_hold, redirect_pc);
    else n_pass++;
    advance();
  endtask

  task automatic test_eret();
    exp_t  e;
    stim_t s[2];
    s[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010);
    s[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3010);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL eret_outs[%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      n_checks++;
      if (redirect_pc !== (i == 0 ? 32'h0000_3010 : 32'h0000_4180) || flush_dem !== 1'b1)
        $display("FAIL eret_pc[%0d] got=%h flush=%b", i, redirect_pc, flush_dem);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_gated_start();
    exp_t  e;
    stim_t s[7];
    s[0] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    s[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    s[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[5] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[6] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL gate_outs[%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      n_checks++;
      if (dut_cnt !== e.cnt) $display("FAIL gate_cnt[%0d] got=%0d want=%0d", i, dut_cnt, e.cnt);
      else n_pass++;
      if (i == 6) begin
        n_checks++;
        if (dut_cnt !== 4'd7) $display("FAIL gate_pre_reset_cnt got=%0d want=7", dut_cnt);
        else n_pass++;
      end
      advance();
    end
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (dut_cnt !== 4'd0 || pc_hold !== 1'b0 || md_busy !== 1'b0 || obs !== e.v)
      $display("FAIL reset_mid_count got cnt=%0d hold=%b busy=%b want 0/0/0", dut_cnt, pc_hold, md_busy);
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t s[9];
    s[0] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    s[1] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    s[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    s[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[5] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    s[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    s[8] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) $display("FAIL b2b_outs[%0d] got=%h want=%h", i, obs, e.v);
      else n_pass++;
      n_checks++;
      if (dut_cnt !== e.cnt) $display("FAIL b2b_cnt[%0d] got=%0d want=%0d", i, dut_cnt, e.cnt);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_mflo();
    test_exception();
    test_eret();
    test_gated_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
